mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Two-port request bus plus the shared data-memory bus of the arbiter.
// The slave modport is the arbiter's view; master is the requesters/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_done;
  logic              p0_err;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_done;
  logic              p1_err;
  logic [DATA_W-1:0] p1_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_done, p0_err, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_done, p1_err, p1_rdata,
    output mem_address, mem_write_data, mem_write, mem_read,
    input  mem_read_data
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_done, p0_err, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_done, p1_err, p1_rdata,
    input  mem_address, mem_write_data, mem_write, mem_read,
    output mem_read_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data memory between two ports.
// Each access runs IDLE -> ACCESS -> RESP; misaligned addresses are
// rejected with err instead of touching memory.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  logic              last_port;
  logic              sel_port;
  logic              pick;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              aligned;

  logic              p0_gnt_q, p1_gnt_q;
  logic              p0_done_q, p1_done_q;
  logic              p0_err_q, p1_err_q;
  logic [DATA_W-1:0] p0_rdata_q, p1_rdata_q;

  assign aligned = (lat_addr[1:0] == 2'b00);

  // On a tie the port not served last wins; otherwise the lone requester wins.
  assign pick = (bus.p0_req && bus.p1_req) ? ~last_port : bus.p1_req;

  assign bus.p0_gnt   = p0_gnt_q;
  assign bus.p1_gnt   = p1_gnt_q;
  assign bus.p0_done  = p0_done_q;
  assign bus.p1_done  = p1_done_q;
  assign bus.p0_err   = p0_err_q;
  assign bus.p1_err   = p1_err_q;
  assign bus.p0_rdata = p0_rdata_q;
  assign bus.p1_rdata = p1_rdata_q;

  // Memory bus is live only in ACCESS; enables also drop during reset so an
  // interrupted access can never commit.
  always_comb begin
    bus.mem_address    = '0;
    bus.mem_write_data = '0;
    bus.mem_write      = 1'b0;
    bus.mem_read       = 1'b0;
    if (state == ACCESS) begin
      bus.mem_address    = lat_addr;
      bus.mem_write_data = lat_wdata;
      bus.mem_write      = lat_we && aligned && !rst;
      bus.mem_read       = !lat_we && aligned && !rst;
    end
  end

  // Arbitration FSM with registered handshake outputs and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_port  <= 1'b1;
      sel_port   <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      p0_gnt_q   <= 1'b0;
      p1_gnt_q   <= 1'b0;
      p0_done_q  <= 1'b0;
      p1_done_q  <= 1'b0;
      p0_err_q   <= 1'b0;
      p1_err_q   <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.p0_req || bus.p1_req) begin
            sel_port  <= pick;
            last_port <= pick;
            lat_we    <= pick ? bus.p1_we    : bus.p0_we;
            lat_addr  <= pick ? bus.p1_addr  : bus.p0_addr;
            lat_wdata <= pick ? bus.p1_wdata : bus.p0_wdata;
            p0_gnt_q  <= ~pick;
            p1_gnt_q  <= pick;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          p0_gnt_q <= 1'b0;
          p1_gnt_q <= 1'b0;
          if (sel_port) begin
            p1_done_q <= 1'b1;
            p1_err_q  <= ~aligned;
            if (!lat_we && aligned) p1_rdata_q <= bus.mem_read_data;
          end else begin
            p0_done_q <= 1'b1;
            p0_err_q  <= ~aligned;
            if (!lat_we && aligned) p0_rdata_q <= bus.mem_read_data;
          end
          state <= RESP;
        end
        RESP: begin
          p0_done_q <= 1'b0;
          p1_done_q <= 1'b0;
          p0_err_q  <= 1'b0;
          p1_err_q  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
